// File: rtl/mgmt_arb_pkg.sv
// Shared types and constants for the management-port arbiter.
// Covers state encoding, requester ids, opcodes and timeout counter helpers.
package mgmt_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CFG_WAIT,
        ST_WAIT_BUSY,
        ST_WAIT_RDY,
        ST_DONE
    } state_t;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_POLL = 1'b1;

    localparam logic [1:0] OP_MDIO_ADDR = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_READ      = 2'b10;

    localparam int TO_W = 12;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [9:0]  addr;
        logic [31:0] wr_data;
        logic        miim_sel;
    } mgmt_cmd_t;

    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [1:0] owner_ack(input logic id);
        return (id == REQ_POLL) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mgmt_rr_arbiter.sv
// Two-way round-robin grant; the last winner loses the next tie.
// The grant is combinational, the history only moves when update is asserted.
module mgmt_rr_arbiter
    import mgmt_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_id
);

    logic last_grant;

    always_comb begin
        grant_id = REQ_HOST;
        case (req)
            2'b01:   grant_id = REQ_HOST;
            2'b10:   grant_id = REQ_POLL;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = REQ_HOST;
        endcase
    end

    // Reset to the poll id so the host wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_POLL;
        end else if (update) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/mgmt_req_arbiter.sv
// Shares the management/MDIO access port between the host and the PHY poll engine.
// Serialises transactions, pulses mgmt_req, waits for completion or timeout, then acks the owner.
module mgmt_req_arbiter
    import mgmt_arb_pkg::*;
#(
    parameter int CFG_LAT = 2,
    parameter int BUSY_TO = 8,
    parameter int DONE_TO = 4096
) (
    input  logic        mgmt_clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req0_opcode,
    input  logic [1:0]  req1_opcode,
    input  logic [9:0]  req0_addr,
    input  logic [9:0]  req1_addr,
    input  logic [31:0] req0_wr_data,
    input  logic [31:0] req1_wr_data,
    input  logic        req0_miim_sel,
    input  logic        req1_miim_sel,
    output logic [1:0]  ack,
    output logic        err,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic [1:0]  mgmt_opcode,
    output logic [9:0]  mgmt_addr,
    output logic [31:0] mgmt_wr_data,
    output logic        mgmt_miim_sel,
    output logic        mgmt_req,
    input  logic        mgmt_miim_rdy,
    input  logic [31:0] mgmt_rd_data
);

    localparam logic [TO_W-1:0] CFG_LIM  = TO_W'(CFG_LAT - 1);
    // rdy is checked from the first WAIT_BUSY cycle; one extra cycle covers the
    // management block's request-to-busy latency before declaring a timeout.
    localparam logic [TO_W-1:0] BUSY_LIM = TO_W'(BUSY_TO + 1);
    localparam logic [TO_W-1:0] DONE_LIM = TO_W'(DONE_TO - 1);

    state_t          state;
    logic            owner;
    logic [TO_W-1:0] cnt;
    logic            grant_id;
    logic            grant_en;
    mgmt_cmd_t       cmd0;
    mgmt_cmd_t       cmd1;
    mgmt_cmd_t       cmd_sel;

    always_comb begin
        cmd0    = '{opcode: req0_opcode, addr: req0_addr, wr_data: req0_wr_data, miim_sel: req0_miim_sel};
        cmd1    = '{opcode: req1_opcode, addr: req1_addr, wr_data: req1_wr_data, miim_sel: req1_miim_sel};
        cmd_sel = (grant_id == REQ_POLL) ? cmd1 : cmd0;
    end

    always_comb begin
        grant_en = (state == ST_IDLE) && (|req_valid);
    end

    mgmt_rr_arbiter u_rr (
        .clk      (mgmt_clk),
        .rst      (reset),
        .req      (req_valid),
        .update   (grant_en),
        .grant_id (grant_id)
    );

    always_ff @(posedge mgmt_clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= REQ_HOST;
            cnt           <= '0;
            ack           <= '0;
            err           <= 1'b0;
            rd_data       <= '0;
            busy          <= 1'b0;
            mgmt_opcode   <= '0;
            mgmt_addr     <= '0;
            mgmt_wr_data  <= '0;
            mgmt_miim_sel <= 1'b0;
            mgmt_req      <= 1'b0;
        end else begin
            mgmt_req <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        owner         <= grant_id;
                        mgmt_opcode   <= cmd_sel.opcode;
                        mgmt_addr     <= cmd_sel.addr;
                        mgmt_wr_data  <= cmd_sel.wr_data;
                        mgmt_miim_sel <= cmd_sel.miim_sel;
                        mgmt_req      <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt   <= '0;
                    state <= mgmt_miim_sel ? ST_WAIT_BUSY : ST_CFG_WAIT;
                end
                ST_CFG_WAIT: begin
                    if (cnt >= CFG_LIM) begin
                        rd_data <= mgmt_rd_data;
                        ack     <= owner_ack(owner);
                        state   <= ST_DONE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!mgmt_miim_rdy) begin
                        cnt   <= '0;
                        state <= ST_WAIT_RDY;
                    end else if (cnt >= BUSY_LIM) begin
                        ack   <= owner_ack(owner);
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_WAIT_RDY: begin
                    if (mgmt_miim_rdy) begin
                        rd_data <= mgmt_rd_data;
                        ack     <= owner_ack(owner);
                        state   <= ST_DONE;
                    end else if (cnt >= DONE_LIM) begin
                        rd_data <= '1;
                        ack     <= owner_ack(owner);
                        err     <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mgmt_req_arbiter.sv
// Scoreboard bench for mgmt_req_arbiter with a behavioural management-block model.
module tb_mgmt_req_arbiter;
    import mgmt_arb_pkg::*;

    localparam int CFG_LAT = 2;
    localparam int BUSY_TO = 8;
    localparam int DONE_TO = 4096;

    typedef struct {
        logic        owner;
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        sel;
        int          mode;   // 0 normal, 1 rdy never falls, 2 rdy never rises
        int          d;
        int          r;
    } txn_t;

    typedef struct {
        logic        owner;
        logic        err;
        logic [31:0] rd;
        int          lat_lo;
        int          lat_hi;
    } exp_t;

    logic        mgmt_clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req0_opcode, req1_opcode;
    logic [9:0]  req0_addr, req1_addr;
    logic [31:0] req0_wr_data, req1_wr_data;
    logic        req0_miim_sel, req1_miim_sel;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rd_data;
    logic        busy;
    logic [1:0]  mgmt_opcode;
    logic [9:0]  mgmt_addr;
    logic [31:0] mgmt_wr_data;
    logic        mgmt_miim_sel;
    logic        mgmt_req;
    logic        mgmt_miim_rdy;
    logic [31:0] mgmt_rd_data;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    txn_t issue_q[$];
    exp_t exp_q[$];
    logic tb_last = REQ_POLL;
    logic [31:0] tb_rd = '0;

    txn_t cur;
    exp_t e;
    logic [9:0] cur_addr_dut;
    bit   in_flight = 0;
    bit   m_busy = 0;
    int   m_k = 0;
    int   req_cyc = 0;
    int   lat;

    mgmt_req_arbiter #(.CFG_LAT(CFG_LAT), .BUSY_TO(BUSY_TO), .DONE_TO(DONE_TO)) dut (
        .mgmt_clk      (mgmt_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req0_opcode   (req0_opcode),
        .req1_opcode   (req1_opcode),
        .req0_addr     (req0_addr),
        .req1_addr     (req1_addr),
        .req0_wr_data  (req0_wr_data),
        .req1_wr_data  (req1_wr_data),
        .req0_miim_sel (req0_miim_sel),
        .req1_miim_sel (req1_miim_sel),
        .ack           (ack),
        .err           (err),
        .rd_data       (rd_data),
        .busy          (busy),
        .mgmt_opcode   (mgmt_opcode),
        .mgmt_addr     (mgmt_addr),
        .mgmt_wr_data  (mgmt_wr_data),
        .mgmt_miim_sel (mgmt_miim_sel),
        .mgmt_req      (mgmt_req),
        .mgmt_miim_rdy (mgmt_miim_rdy),
        .mgmt_rd_data  (mgmt_rd_data)
    );

    initial mgmt_clk = 1'b0;
    always #5 mgmt_clk = ~mgmt_clk;
    always @(posedge mgmt_clk) cyc++;

    function automatic logic [31:0] cfg_val(input logic [9:0] a);
        return 32'h1234_5478 ^ {22'h0, a};
    endfunction

    function automatic logic [31:0] mdio_val(input logic [9:0] a);
        return {16'h0, 16'h7949 ^ {6'h0, a}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Management block model plus monitor/scoreboard, all evaluated on the falling edge.
    always @(negedge mgmt_clk) begin
        if (reset) begin
            in_flight     = 0;
            m_busy        = 0;
            mgmt_miim_rdy = 1'b1;
            mgmt_rd_data  = $urandom;
        end else begin
            chk("busy", 32'(busy), 32'(mgmt_req || in_flight));
            if (ack != 2'b00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_ack: got ack=%b expected no ack", ack);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", 32'(ack), 32'(e.owner ? 2'b10 : 2'b01));
                    chk("err", 32'(err), 32'(e.err));
                    chk("rd_data", rd_data, e.rd);
                    chk("addr_hold", 32'(mgmt_addr), 32'(cur.addr));
                    lat = cyc - req_cyc;
                    checks++;
                    if (lat < e.lat_lo || lat > e.lat_hi) begin
                        failures++;
                        $display("FAIL ack_latency: got %0d expected %0d..%0d", lat, e.lat_lo, e.lat_hi);
                    end
                end
                in_flight = 0;
                m_busy    = 0;
            end
            if (mgmt_req) begin
                if (in_flight || issue_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got mgmt_req=1 expected 0 (in_flight=%0d)", in_flight);
                end else begin
                    cur = issue_q.pop_front();
                    chk("mgmt_addr", 32'(mgmt_addr), 32'(cur.addr));
                    chk("mgmt_opcode", 32'(mgmt_opcode), 32'(cur.op));
                    chk("mgmt_wr_data", mgmt_wr_data, cur.wd);
                    chk("mgmt_miim_sel", 32'(mgmt_miim_sel), 32'(cur.sel));
                end
                in_flight    = 1;
                m_busy       = 1;
                m_k          = 0;
                req_cyc      = cyc;
                cur_addr_dut = mgmt_addr;
            end else if (m_busy) begin
                m_k++;
            end
            mgmt_miim_rdy = 1'b1;
            mgmt_rd_data  = $urandom;
            if (m_busy) begin
                if (!cur.sel) begin
                    if (m_k >= CFG_LAT) mgmt_rd_data = cfg_val(cur_addr_dut);
                end else if (cur.mode == 0) begin
                    if (m_k >= cur.d + cur.r) mgmt_rd_data = mdio_val(cur_addr_dut);
                    else if (m_k >= cur.d) mgmt_miim_rdy = 1'b0;
                end else if (cur.mode == 2) begin
                    if (m_k >= cur.d) mgmt_miim_rdy = 1'b0;
                end
            end
        end
    end

    function automatic txn_t mk(input logic o, input logic [1:0] op, input logic [9:0] a,
                                input logic [31:0] wd, input logic s, input int mode,
                                input int d, input int r);
        txn_t t;
        t.owner = o; t.op = op; t.addr = a; t.wd = wd; t.sel = s;
        t.mode = mode; t.d = d; t.r = r;
        return t;
    endfunction

    function automatic txn_t rand_txn(input logic o);
        logic s;
        int   mode;
        s    = 1'($urandom_range(0, 1));
        mode = (s && $urandom_range(0, 7) == 0) ? 1 : 0;
        return mk(o, 2'($urandom_range(0, 2)), 10'($urandom), $urandom, s, mode,
                  $urandom_range(1, 6), $urandom_range(1, 30));
    endfunction

    task automatic push_txn(input txn_t t);
        exp_t x;
        x.owner = t.owner;
        if (!t.sel) begin
            x.err = 0; x.rd = cfg_val(t.addr); x.lat_lo = CFG_LAT + 1; x.lat_hi = CFG_LAT + 1;
        end else if (t.mode == 0) begin
            x.err = 0; x.rd = mdio_val(t.addr); x.lat_lo = 1 + t.d + t.r; x.lat_hi = 1 + t.d + t.r;
        end else if (t.mode == 1) begin
            x.err = 1; x.rd = tb_rd; x.lat_lo = BUSY_TO + 3; x.lat_hi = BUSY_TO + 3;
        end else begin
            x.err = 1; x.rd = 32'hFFFF_FFFF; x.lat_lo = DONE_TO; x.lat_hi = DONE_TO + t.d + 4;
        end
        tb_rd   = x.rd;
        tb_last = t.owner;
        issue_q.push_back(t);
        exp_q.push_back(x);
    endtask

    task automatic issue_round(input logic [1:0] mask, input txn_t t0, input txn_t t1);
        if (mask == 2'b11) begin
            if (tb_last == REQ_POLL) begin push_txn(t0); push_txn(t1); end
            else begin push_txn(t1); push_txn(t0); end
        end else if (mask == 2'b01) begin
            push_txn(t0);
        end else begin
            push_txn(t1);
        end
        req0_opcode = t0.op; req0_addr = t0.addr; req0_wr_data = t0.wd; req0_miim_sel = t0.sel;
        req1_opcode = t1.op; req1_addr = t1.addr; req1_wr_data = t1.wd; req1_miim_sel = t1.sel;
        req_valid = mask;
    endtask

    task automatic wait_done(input bit drop_early);
        bit ok = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge mgmt_clk);
            for (int i = 0; i < 2; i++) if (ack[i]) req_valid[i] = 1'b0;
            if (drop_early && busy && !mgmt_req) req_valid[0] = 1'b0;
            if (req_valid == 2'b00 && exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_done: got %0d acks outstanding expected 0", exp_q.size());
            exp_q.delete();
            issue_q.delete();
            req_valid = 2'b00;
        end
    endtask

    task automatic round(input logic [1:0] mask, input txn_t t0, input txn_t t1, input bit drop_early);
        issue_round(mask, t0, t1);
        wait_done(drop_early);
    endtask

    initial begin
        txn_t idle0, idle1;
        idle0 = mk(REQ_HOST, OP_READ, '0, '0, 1'b0, 0, 1, 1);
        idle1 = mk(REQ_POLL, OP_READ, '0, '0, 1'b0, 0, 1, 1);
        reset = 1'b1;
        req_valid = '0;
        req0_opcode = '0; req0_addr = '0; req0_wr_data = '0; req0_miim_sel = 1'b0;
        req1_opcode = '0; req1_addr = '0; req1_wr_data = '0; req1_miim_sel = 1'b0;
        repeat (3) @(negedge mgmt_clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mgmt_req", 32'(mgmt_req), 32'h0);
        chk("rst_mgmt_addr", 32'(mgmt_addr), 32'h0);
        chk("rst_mgmt_opcode", 32'(mgmt_opcode), 32'h0);
        chk("rst_mgmt_wr_data", mgmt_wr_data, 32'h0);
        chk("rst_mgmt_miim_sel", 32'(mgmt_miim_sel), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge mgmt_clk);

        // Simultaneous requests twice: host, poll, host, poll.
        round(2'b11, mk(REQ_HOST, OP_READ, 10'h011, 32'h0, 1'b0, 0, 1, 1),
                     mk(REQ_POLL, OP_READ, 10'h022, 32'h0, 1'b1, 0, 2, 5), 0);
        round(2'b11, mk(REQ_HOST, OP_WRITE, 10'h033, 32'hCAFE_0001, 1'b0, 0, 1, 1),
                     mk(REQ_POLL, OP_READ, 10'h044, 32'h0, 1'b0, 0, 1, 1), 0);
        // Host config read.
        round(2'b01, mk(REQ_HOST, OP_READ, 10'h200, 32'h0, 1'b0, 0, 1, 1), idle1, 0);
        // Poll MDIO read with a long busy window.
        round(2'b10, idle0, mk(REQ_POLL, OP_READ, 10'h000, 32'h0, 1'b1, 0, 2, 100), 0);
        // MDIO busy timeout, then completion timeout.
        round(2'b01, mk(REQ_HOST, OP_READ, 10'h155, 32'h0, 1'b1, 1, 1, 1), idle1, 0);
        round(2'b01, mk(REQ_HOST, OP_MDIO_ADDR, 10'h0AA, 32'h1, 1'b1, 2, 2, 1), idle1, 0);
        // Host drops its request while the config access is in flight.
        round(2'b01, mk(REQ_HOST, OP_READ, 10'h3C3, 32'h0, 1'b0, 0, 1, 1), idle1, 1);
        repeat (10) @(negedge mgmt_clk);

        for (int n = 0; n < 30; n++) begin
            round(2'($urandom_range(1, 3)), rand_txn(REQ_HOST), rand_txn(REQ_POLL), 0);
            repeat ($urandom_range(0, 3)) @(negedge mgmt_clk);
        end

        // Reset in the middle of WAIT_RDY.
        issue_round(2'b01, mk(REQ_HOST, OP_READ, 10'h101, 32'h0, 1'b1, 2, 2, 1), idle1);
        repeat (15) @(negedge mgmt_clk);
        req_valid = 2'b00;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ack", 32'(ack), 32'h0);
        chk("midrst_mgmt_req", 32'(mgmt_req), 32'h0);
        exp_q.delete();
        issue_q.delete();
        tb_rd = '0;
        tb_last = REQ_POLL;
        repeat (2) @(negedge mgmt_clk);
        reset = 1'b0;
        repeat (5) @(negedge mgmt_clk);
        round(2'b11, mk(REQ_HOST, OP_READ, 10'h2F0, 32'h0, 1'b0, 0, 1, 1),
                     mk(REQ_POLL, OP_READ, 10'h0F2, 32'h0, 1'b0, 0, 1, 1), 0);
        repeat (5) @(negedge mgmt_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mgmt_req_arbiter.md
Name: mgmt_req_arbiter

Overview:
- Shares the single management-register/MDIO access port (opcode/addr/wr_data/miim_sel/req, miim_rdy, rd_data) between two requesters.
- Requester 0 is the host. Requester 1 is the PHY auto-poll engine.
- Serialises transactions, sequences the mgmt_req pulse and the completion handshake, captures read data, and applies MDIO timeouts.
- Sits between the host bus/poll logic and the management block, in the mgmt_clk domain.

Parameters:
- CFG_LAT, 2: cycles from the mgmt_req pulse until mgmt_rd_data is valid for internal (miim_sel=0) accesses; legal range 1..15.
- BUSY_TO, 8: max cycles to wait for mgmt_miim_rdy to fall after an MDIO mgmt_req.
- DONE_TO, 4096: max cycles to wait for mgmt_miim_rdy to rise again.

Ports:
- mgmt_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request, level, held until ack
- req0_opcode/req1_opcode  in  2 each  opcode
- req0_addr/req1_addr  in  10 each  address
- req0_wr_data/req1_wr_data  in  32 each  write data
- req0_miim_sel/req1_miim_sel  in  1 each  0 = config/stat register, 1 = MDIO
- ack  out  2  one-cycle completion pulse, one-hot to the owner
- err  out  1  valid with ack; 1 = timeout
- rd_data  out  32  captured read data, valid from ack until the next ack
- busy  out  1  transaction in flight
- mgmt_opcode  out  2  to management block
- mgmt_addr  out  10  to management block
- mgmt_wr_data  out  32  to management block
- mgmt_miim_sel  out  1  to management block
- mgmt_req  out  1  one-cycle request pulse
- mgmt_miim_rdy  in  1  management idle
- mgmt_rd_data  in  32  management read data

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=1 (so requester 0 wins the first tie), counters 0.
- All outputs are registered.
- States:
  - IDLE: if any req_valid, grant and latch the owner's fields into the mgmt_* registers, then go to REQ.
  - REQ: mgmt_req=1 for exactly this cycle. Go to CFG_WAIT if miim_sel=0, else WAIT_BUSY.
  - CFG_WAIT: count CFG_LAT cycles. On the last cycle, rd_data<=mgmt_rd_data and go to DONE.
  - WAIT_BUSY: when mgmt_miim_rdy=0, go to WAIT_RDY (this can happen in the first WAIT_BUSY cycle). After BUSY_TO cycles with rdy still 1, go to DONE with err.
  - WAIT_RDY: when mgmt_miim_rdy=1, rd_data<=mgmt_rd_data and go to DONE. After DONE_TO cycles, go to DONE with err and rd_data<=32'hFFFF_FFFF.
  - DONE: ack[owner]=1 and err valid, then go to IDLE.
- Arbitration (IDLE only):
  - Only one valid: that requester wins.
  - Both valid: the requester that is not last_grant wins; last_grant<=winner.
  - Strict alternation under continuous contention.
- mgmt_opcode/addr/wr_data/miim_sel are held stable from REQ through DONE. They keep their last values in IDLE.
- busy=1 in REQ through DONE.
- Latency for config access: req sampled in IDLE at t0; mgmt_req at t1; ack at t2+CFG_LAT (t4 with the default).
- A requester whose req_valid drops mid-transaction still receives ack; the transaction is not aborted.
- req_valid still high the cycle after ack is a new request, arbitrated normally. The minimum gap between transactions is one IDLE cycle.
- A request from the non-owner during busy waits; it is never lost and never acked early.
- An MDIO write still captures rd_data (contents are don't-care). err=0 on success.
- Timeout counters are 12 bits, cleared on state entry, and saturate.
- Reset asserted mid-transaction: immediately IDLE, mgmt_req=0, no ack issued. The pending requester must re-request.

Decomposition:
- Package mgmt_arb_pkg:
  - state encoding (IDLE, REQ, CFG_WAIT, WAIT_BUSY, WAIT_RDY, DONE)
  - requester ids REQ_HOST=0, REQ_POLL=1
  - opcode constants (write, read, MDIO)
  - timeout counter width
- Sub-module mgmt_rr_arbiter: 2-way round-robin grant with last_grant register and an update enable.

Test Plan:
- Host config read, addr 10'h200, miim_sel=0, mgmt_rd_data=32'h1234_5678: mgmt_req pulses 1 cycle at t1; ack=2'b01 at t4; rd_data=32'h1234_5678; err=0.
- Both requesters assert in the same cycle after reset, then again after completion: host served first, poll second, host third; mgmt_req never asserted while busy.
- Poll MDIO read: model drops miim_rdy 2 cycles after mgmt_req and raises it 100 cycles later with data 16'h7949 zero-extended: ack=2'b10 on the cycle after rdy rises; rd_data=32'h0000_7949.
- miim_rdy never falls after an MDIO request: ack plus err=1 at BUSY_TO+3 cycles after mgmt_req; rd_data unchanged. Second case, rdy falls but never rises: err=1 after DONE_TO; rd_data=32'hFFFF_FFFF.
- Reset pulsed during WAIT_RDY: busy=0, no ack. Host re-request afterwards completes normally; last_grant=1 so the host wins against a simultaneous poll request.
- Host drops req_valid in CFG_WAIT: ack[0] still pulses once; no second transaction is issued.
